// File: rtl/note_sequencer_if.sv
// Bundle of the live-note, timebase, button and oscillator-side signals of note_sequencer.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a plain level or one-cycle pulse.
// Ports: master = driver/tick/button side plus output observer, slave = the sequencer itself.
interface note_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic [17:0]     divider_in;
  logic            strobe_in;
  logic            tick;
  logic            rec_btn;
  logic            play_btn;
  logic [17:0]     divider_out;
  logic            note_active;
  logic [1:0]      state;
  logic [ADDR_W:0] count;
  logic            full;

  modport master (
    output divider_in, strobe_in, tick, rec_btn, play_btn,
    input  divider_out, note_active, state, count, full
  );

  modport slave (
    input  divider_in, strobe_in, tick, rec_btn, play_btn,
    output divider_out, note_active, state, count, full
  );
endinterface

// File: rtl/note_sequencer.sv
// Record/playback sequencer between the keypad driver and the oscillator.
// Latency: divider_out/note_active are registered, one cycle after the live input or playback event.
// No backpressure: inputs are sampled every cycle, the tick pulse is the only timebase.
// Ports: clk, nrst (async active-low); bus.slave carries divider_in/strobe_in/tick/rec_btn/play_btn
// in and divider_out/note_active/state/count/full out.
module note_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DUR_W  = 8
) (
  input  logic             clk,
  input  logic             nrst,
  note_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10
  } state_t;

  typedef struct packed {
    logic [17:0]      val;
    logic [DUR_W-1:0] dur;
  } entry_t;

  localparam logic [DUR_W-1:0]  DUR_MAX = {DUR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  entry_t           seg_buf [DEPTH];
  state_t           st;
  logic             rec_q;
  logic             play_q;
  logic [ADDR_W:0]  cnt;
  logic             seg_open;
  logic [17:0]      seg_val;
  logic [DUR_W-1:0] seg_dur;
  logic [ADDR_W-1:0] pidx;
  logic [DUR_W-1:0] pcnt;
  logic [17:0]      dout;
  logic             act;

  logic [17:0]      live;
  logic             rec_press;
  logic             play_press;
  logic [DUR_W-1:0] dur_nxt;
  logic             changed;
  logic             sat;
  logic             wr_en;
  entry_t           wr_dat;
  entry_t           cur_ent;
  entry_t           nxt_ent;
  logic [ADDR_W-1:0] nidx;
  logic [DUR_W-1:0] pcnt_inc;
  logic             seg_end;
  logic [17:0]      out_nxt;

  always_comb begin
    live       = bus.strobe_in ? bus.divider_in : 18'd0;
    rec_press  = bus.rec_btn & ~rec_q;
    play_press = bus.play_btn & ~play_q;
    dur_nxt    = seg_dur + DUR_W'(bus.tick);
    changed    = (live != seg_val);
    sat        = (dur_nxt == DUR_MAX);

    // A tick in the same cycle as a close event belongs to the closing segment,
    // and a saturated segment always has dur_nxt == DUR_MAX, so one write path covers all cases.
    wr_en        = 1'b0;
    wr_dat.val   = seg_val;
    wr_dat.dur   = dur_nxt;
    if (st == S_REC && cnt != CNT_MAX && seg_open && (rec_press || sat || changed)) begin
      wr_en = (dur_nxt != '0);
    end

    cur_ent  = seg_buf[pidx];
    nidx     = (({1'b0, pidx} + CNT_ONE) == cnt) ? '0 : pidx + 1'b1;
    nxt_ent  = seg_buf[nidx];
    pcnt_inc = pcnt + 1'b1;
    seg_end  = bus.tick && (pcnt_inc == cur_ent.dur);

    out_nxt = live;
    case (st)
      S_IDLE: begin
        if (!rec_press && play_press && cnt != '0) begin
          out_nxt = seg_buf[0].val;
        end
      end
      S_PLAY: begin
        if (play_press) begin
          out_nxt = live;
        end else if (seg_end) begin
          out_nxt = nxt_ent.val;
        end else begin
          out_nxt = cur_ent.val;
        end
      end
      default: out_nxt = live;
    endcase
  end

  // Buffer contents survive reset; count=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      seg_buf[cnt[ADDR_W-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st       <= S_IDLE;
      // Edge detectors start high so a button held through reset release is not a press.
      rec_q    <= 1'b1;
      play_q   <= 1'b1;
      cnt      <= '0;
      seg_open <= 1'b0;
      seg_val  <= '0;
      seg_dur  <= '0;
      pidx     <= '0;
      pcnt     <= '0;
      dout     <= '0;
      act      <= 1'b0;
    end else begin
      rec_q  <= bus.rec_btn;
      play_q <= bus.play_btn;
      dout   <= out_nxt;
      act    <= (out_nxt != 18'd0);

      case (st)
        S_IDLE: begin
          if (rec_press) begin
            st       <= S_REC;
            cnt      <= '0;
            seg_open <= 1'b0;
            seg_dur  <= '0;
          end else if (play_press && cnt != '0) begin
            st   <= S_PLAY;
            pidx <= '0;
            pcnt <= '0;
          end
        end

        S_REC: begin
          if (cnt == CNT_MAX) begin
            st <= S_IDLE;
          end else begin
            if (wr_en) begin
              cnt <= cnt + CNT_ONE;
            end
            if (rec_press) begin
              st       <= S_IDLE;
              seg_open <= 1'b0;
              seg_dur  <= '0;
            end else if (!seg_open) begin
              // Leading silence is not recorded; the first sound opens the first segment.
              if (live != 18'd0) begin
                seg_open <= 1'b1;
                seg_val  <= live;
                seg_dur  <= '0;
              end
            end else if (changed || sat) begin
              seg_val <= live;
              seg_dur <= '0;
            end else begin
              seg_dur <= dur_nxt;
            end
          end
        end

        S_PLAY: begin
          if (play_press) begin
            st <= S_IDLE;
          end else if (bus.tick) begin
            if (seg_end) begin
              pidx <= nidx;
              pcnt <= '0;
            end else begin
              pcnt <= pcnt_inc;
            end
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.divider_out = dout;
  assign bus.note_active = act;
  assign bus.state       = st;
  assign bus.count       = cnt;
  assign bus.full        = (cnt == CNT_MAX);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expected divider values are queued as each cycle is driven
// and compared after the edge; playback expectations come from the recorded-entry tables.
module tb_note_sequencer;
  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if #(.ADDR_W(4)) bus ();

  note_sequencer #(.DEPTH(16), .ADDR_W(4), .DUR_W(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          phase = 0;       // tick fires on the edge of a step where phase == 3
  logic [17:0] vcur  = '0;
  logic [17:0] sb_q [$];
  logic [17:0] ent_val [16];
  int          ent_dur [16];
  int          n_ent = 0;
  int          m_idx = 0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_v(input logic [17:0] d);
    vcur           = d;
    bus.strobe_in  = (d != 18'd0);
    bus.divider_in = (d != 18'd0) ? d : 18'd12345;  // ignored while no key is held
  endtask

  // One clock: drive tick, queue the expected output, compare after the edge.
  task automatic step(input bit en, input logic [17:0] e);
    logic [17:0] x;
    bus.tick = (phase == 3);
    phase    = (phase + 1) % 4;
    if (en) sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    if (en) begin
      x = sb_q.pop_front();
      chk("div", bus.divider_out, x);
      chk("act", bus.note_active, (x != 18'd0));
    end
  endtask

  task automatic hold(input logic [17:0] d, input int n);
    set_v(d);
    repeat (n) step(1'b1, vcur);
  endtask

  task automatic align();
    while (phase != 0) step(1'b1, vcur);
  endtask

  task automatic press_rec();
    bus.rec_btn = 1'b1;
    step(1'b1, vcur);
    bus.rec_btn = 1'b0;
  endtask

  task automatic play_start();
    bus.play_btn = 1'b1;
    m_idx = 0;
    m_cnt = 0;
    step(1'b1, ent_val[0]);
    bus.play_btn = 1'b0;
    chk("play_state", bus.state, 2);
  endtask

  task automatic play_run(input int ncyc);
    repeat (ncyc) begin
      if (phase == 3) begin
        m_cnt++;
        if (m_cnt == ent_dur[m_idx]) begin
          m_idx = (m_idx + 1) % n_ent;
          m_cnt = 0;
        end
      end
      step(1'b1, ent_val[m_idx]);
    end
  endtask

  task automatic play_stop();
    bus.play_btn = 1'b1;
    step(1'b1, vcur);
    bus.play_btn = 1'b0;
    chk("stop_state", bus.state, 0);
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.rec_btn = 1'b0;
    bus.play_btn = 1'b0;
    set_v(18'd0);

    // Reset state
    #2 nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_div", bus.divider_out, 0);
    chk("rst_act", bus.note_active, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    nrst = 1'b1;
    step(1'b1, 18'd0);

    // Live passthrough in IDLE
    hold(18'd4242, 3);
    hold(18'd0, 2);

    // Simultaneous rec+play in IDLE: rec wins
    bus.rec_btn = 1'b1;
    bus.play_btn = 1'b1;
    step(1'b1, vcur);
    bus.rec_btn = 1'b0;
    bus.play_btn = 1'b0;
    chk("both_state", bus.state, 1);
    step(1'b1, vcur);
    press_rec();
    chk("empty_state", bus.state, 0);
    chk("empty_count", bus.count, 0);
    // Play with nothing stored is ignored
    bus.play_btn = 1'b1;
    step(1'b1, vcur);
    bus.play_btn = 1'b0;
    step(1'b1, vcur);
    chk("play_empty_state", bus.state, 0);

    // Record and replay: 1000 x3 ticks, silence x2, 2000 x1
    press_rec();
    chk("rec_state", bus.state, 1);
    align();
    hold(18'd1000, 12);
    hold(18'd0, 8);
    hold(18'd2000, 4);
    hold(18'd0, 1);
    press_rec();
    chk("rr_state", bus.state, 0);
    chk("rr_count", bus.count, 3);
    n_ent = 3;
    ent_val[0] = 18'd1000; ent_dur[0] = 3;
    ent_val[1] = 18'd0;    ent_dur[1] = 2;
    ent_val[2] = 18'd2000; ent_dur[2] = 1;
    play_start();
    play_run(40);
    // rec press during PLAY is ignored
    bus.rec_btn = 1'b1;
    play_run(1);
    bus.rec_btn = 1'b0;
    play_run(6);
    chk("play_rec_ign", bus.state, 2);

    // Asynchronous reset mid-PLAY
    nrst = 1'b0;
    #1;
    chk("arst_state", bus.state, 0);
    chk("arst_div", bus.divider_out, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_act", bus.note_active, 0);
    @(posedge clk);
    #1 nrst = 1'b1;
    step(1'b1, vcur);

    // Glitch filter: 1000 -> 2000 -> 3000 with no tick on 2000
    press_rec();
    align();
    hold(18'd1000, 8);
    hold(18'd2000, 1);
    hold(18'd3000, 7);
    hold(18'd0, 1);
    press_rec();
    chk("glitch_count", bus.count, 2);
    n_ent = 2;
    ent_val[0] = 18'd1000; ent_dur[0] = 2;
    ent_val[1] = 18'd3000; ent_dur[1] = 2;
    play_start();
    play_run(24);
    play_stop();
    hold(18'd777, 3);
    hold(18'd0, 2);

    // Saturation: 300 ticks of 5000 then 1 tick of 6000
    press_rec();
    align();
    hold(18'd5000, 1200);
    hold(18'd6000, 4);
    hold(18'd0, 1);
    press_rec();
    chk("sat_count", bus.count, 3);
    n_ent = 3;
    ent_val[0] = 18'd5000; ent_dur[0] = 255;
    ent_val[1] = 18'd5000; ent_dur[1] = 45;
    ent_val[2] = 18'd6000; ent_dur[2] = 1;
    play_start();
    play_run(1300);
    play_stop();

    // Full: 16 segments of one tick each
    press_rec();
    align();
    for (int i = 0; i < 16; i++) hold(18'(100 * (i + 1)), 4);
    hold(18'd1700, 1);
    chk("full_count", bus.count, 16);
    chk("full_rec_state", bus.state, 1);
    step(1'b1, vcur);
    chk("full_idle_state", bus.state, 0);
    chk("full_flag", bus.full, 1);
    hold(18'd4321, 4);
    hold(18'd0, 4);
    chk("full_count_hold", bus.count, 16);
    chk("full_flag_hold", bus.full, 1);

    // Button held through reset release does not fire
    bus.rec_btn = 1'b1;
    nrst = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    step(1'b1, vcur);
    step(1'b1, vcur);
    chk("held_btn_state", bus.state, 0);
    chk("held_btn_full", bus.full, 0);
    bus.rec_btn = 1'b0;
    step(1'b1, vcur);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
